// File: rtl/die_roll_decoder.sv
// Die selector latch and roll generator: free-running modulo-N counter sampled after a timed roll,
// or a 16-bit Galois LFSR with rejection sampling when DIE_LFSR_EN is defined.
`timescale 1ns/1ps
module die_roll_decoder #(
    parameter int unsigned ROLL_CYCLES = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dieSelect,
    input  logic       rollReq,
    output logic [4:0] dieSides,
    output logic       testMode,
    output logic       selError,
    output logic       busy,
    output logic [4:0] rollValue,
    output logic       rollValid
);
    typedef enum logic [1:0] {IDLE, ROLLING, DONE, HOLD} state_t;

    localparam int unsigned     TW         = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(ROLL_CYCLES - 1);

    if (ROLL_CYCLES < 1) begin : g_bad_roll
        $error("ROLL_CYCLES must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    function automatic logic is_die_code(input logic [3:0] code);
        return code <= 4'd5;
    endfunction

    function automatic logic [4:0] sides_of(input logic [3:0] code);
        case (code)
            4'd0:    return 5'd4;
            4'd1:    return 5'd6;
            4'd2:    return 5'd8;
            4'd3:    return 5'd10;
            4'd4:    return 5'd12;
            4'd5:    return 5'd20;
            default: return 5'd4;
        endcase
    endfunction

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [4:0]        sides_q;
    logic              test_q;
    logic [4:0]        value_q;
    logic              valid_q;
    logic [4:0]        test_next_q;
    logic [4:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              prev_q;
    logic              req_sync;
    logic              roll_start;

    // Synchronizer and edge history reset high so a button held through reset must be released first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rollReq};
            prev_q <= req_sync;
        end
    end

    assign req_sync   = sync_q[SYNC_STAGES-1];
    assign roll_start = req_sync & ~prev_q;

    // A shrink of dieSides leaves cnt possibly >= sides; the >= compare folds that into the wrap.
    assign cnt_d = (cnt_q >= sides_q - 5'd1) ? 5'd0 : cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 5'd0;
        else        cnt_q <= cnt_d;
    end

`ifdef DIE_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            sides_q     <= 5'd4;
            test_q      <= 1'b0;
            value_q     <= 5'd0;
            valid_q     <= 1'b0;
            test_next_q <= 5'd1;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_die_code(dieSelect)) begin
                        sides_q <= sides_of(dieSelect);
                        test_q  <= 1'b0;
                    end else if (dieSelect == 4'd7) begin
                        test_q  <= 1'b1;
                    end
                    if (roll_start) begin
                        state_q <= ROLLING;
                        timer_q <= TIMER_LOAD;
                    end
                end
                ROLLING: begin
                    if (timer_q == '0) state_q <= DONE;
                    else               timer_q <= timer_q - TW'(1);
                end
                DONE: begin
                    if (test_q) begin
                        value_q     <= test_next_q;
                        test_next_q <= (test_next_q == 5'd20) ? 5'd1 : test_next_q + 5'd1;
                        valid_q     <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
`ifdef DIE_LFSR_EN
                        // Out-of-range candidates are rejected so every face stays equally likely.
                        if (lfsr_q[4:0] < sides_q) begin
                            value_q <= lfsr_q[4:0] + 5'd1;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
`else
                        value_q <= cnt_q + 5'd1;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (!req_sync) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dieSides  = sides_q;
    assign testMode  = test_q;
    assign selError  = !(is_die_code(dieSelect) || dieSelect == 4'd7);
    assign busy      = (state_q != IDLE);
    assign rollValue = value_q;
    assign rollValid = valid_q;

endmodule
